// File: rtl/dnn_pkg.sv
// Shared constants and types for the dnn inference core and its stream loader.
package dnn_pkg;

    // Word width of activations and weights (signed); the core only supports 5.
    localparam int DW = 5;

    localparam int NUM_X  = 4;
    localparam int NUM_W1 = 16;
    localparam int NUM_W2 = 8;

    // Frame lengths in words.
    localparam int FRAME_X_LEN    = NUM_X;
    localparam int FRAME_FULL_LEN = NUM_X + NUM_W1 + NUM_W2;

    // Position of every value inside a full frame (0-based word index).
    localparam int IDX_X0  = 0;
    localparam int IDX_X1  = 1;
    localparam int IDX_X2  = 2;
    localparam int IDX_X3  = 3;
    localparam int IDX_W04 = 4;
    localparam int IDX_W05 = 5;
    localparam int IDX_W06 = 6;
    localparam int IDX_W07 = 7;
    localparam int IDX_W14 = 8;
    localparam int IDX_W15 = 9;
    localparam int IDX_W16 = 10;
    localparam int IDX_W17 = 11;
    localparam int IDX_W24 = 12;
    localparam int IDX_W25 = 13;
    localparam int IDX_W26 = 14;
    localparam int IDX_W27 = 15;
    localparam int IDX_W34 = 16;
    localparam int IDX_W35 = 17;
    localparam int IDX_W36 = 18;
    localparam int IDX_W37 = 19;
    localparam int IDX_W48 = 20;
    localparam int IDX_W49 = 21;
    localparam int IDX_W58 = 22;
    localparam int IDX_W59 = 23;
    localparam int IDX_W68 = 24;
    localparam int IDX_W69 = 25;
    localparam int IDX_W78 = 26;
    localparam int IDX_W79 = 27;

    // Word counter indices where s_last may legally appear.
    localparam logic [4:0] CNT_LAST_X    = 5'(FRAME_X_LEN - 1);
    localparam logic [4:0] CNT_LAST_FULL = 5'(FRAME_FULL_LEN - 1);

    // Loader state: LOAD accepts words, FIRE is the single in_ready cycle.
    typedef enum logic {
        LOAD = 1'b0,
        FIRE = 1'b1
    } ldr_state_e;

endpackage

// File: rtl/dnn_stream_loader.sv
// Serial-to-parallel loader for the dnn core: stages a framed 5-bit word
// stream, validates framing, and commits activations/weights atomically.
module dnn_stream_loader #(
    parameter int DW = dnn_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic signed [DW-1:0] x0,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic signed [DW-1:0] x3,
    output logic signed [DW-1:0] w04,
    output logic signed [DW-1:0] w05,
    output logic signed [DW-1:0] w06,
    output logic signed [DW-1:0] w07,
    output logic signed [DW-1:0] w14,
    output logic signed [DW-1:0] w15,
    output logic signed [DW-1:0] w16,
    output logic signed [DW-1:0] w17,
    output logic signed [DW-1:0] w24,
    output logic signed [DW-1:0] w25,
    output logic signed [DW-1:0] w26,
    output logic signed [DW-1:0] w27,
    output logic signed [DW-1:0] w34,
    output logic signed [DW-1:0] w35,
    output logic signed [DW-1:0] w36,
    output logic signed [DW-1:0] w37,
    output logic signed [DW-1:0] w48,
    output logic signed [DW-1:0] w49,
    output logic signed [DW-1:0] w58,
    output logic signed [DW-1:0] w59,
    output logic signed [DW-1:0] w68,
    output logic signed [DW-1:0] w69,
    output logic signed [DW-1:0] w78,
    output logic signed [DW-1:0] w79,
    output logic                 in_ready,
    output logic                 w_valid,
    output logic                 frame_err
);

    localparam int LEN = dnn_pkg::FRAME_FULL_LEN;

    dnn_pkg::ldr_state_e r_state;
    logic [4:0]          r_cnt;
    logic                r_w_valid;
    logic                r_frame_err;

    // Staging holds the frame in flight; commit holds what the core sees.
    logic signed [DW-1:0] r_stage  [LEN];
    logic signed [DW-1:0] r_commit [LEN];

    logic w_accept;
    logic w_good_x;
    logic w_good_full;
    logic w_good;
    logic w_err;

    // Handshake and framing decode for the word currently offered.
    assign w_accept    = s_valid && (r_state == dnn_pkg::LOAD);
    assign w_good_x    = w_accept && s_last && (r_cnt == dnn_pkg::CNT_LAST_X) && r_w_valid;
    assign w_good_full = w_accept && s_last && (r_cnt == dnn_pkg::CNT_LAST_FULL);
    assign w_good      = w_good_x || w_good_full;
    // Any s_last that is not a good frame end, or a 28th word lacking s_last.
    assign w_err       = w_accept && !w_good && (s_last || (r_cnt == dnn_pkg::CNT_LAST_FULL));

    assign s_ready   = (r_state == dnn_pkg::LOAD);
    assign in_ready  = (r_state == dnn_pkg::FIRE);
    assign w_valid   = r_w_valid;
    assign frame_err = r_frame_err;

    // Control path: state, word counter, weight-valid flag and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= dnn_pkg::LOAD;
            r_cnt       <= 5'd0;
            r_w_valid   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            case (r_state)
                dnn_pkg::LOAD: begin
                    if (w_err) begin
                        r_cnt <= 5'd0;
                    end else if (w_good) begin
                        r_cnt   <= 5'd0;
                        r_state <= dnn_pkg::FIRE;
                        if (w_good_full) begin
                            r_w_valid <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= dnn_pkg::LOAD;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LEN; gi++) begin : g_word
            // Staging slot: capture its word, wiped when a frame is rejected.
            always_ff @(posedge clk) begin
                if (rst || w_err) begin
                    r_stage[gi] <= '0;
                end else if (w_accept && (r_cnt == 5'(gi))) begin
                    r_stage[gi] <= s_data;
                end
            end

            // Commit slot: the final word bypasses staging since it is being
            // accepted on this very edge.
            if (gi < dnn_pkg::NUM_X) begin : g_x
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_commit[gi] <= '0;
                    end else if (w_good) begin
                        r_commit[gi] <= (r_cnt == 5'(gi)) ? s_data : r_stage[gi];
                    end
                end
            end else begin : g_w
                // Weights only move on a full frame; input-only frames reuse them.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_commit[gi] <= '0;
                    end else if (w_good_full) begin
                        r_commit[gi] <= (r_cnt == 5'(gi)) ? s_data : r_stage[gi];
                    end
                end
            end
        end
    endgenerate

    assign x0  = r_commit[dnn_pkg::IDX_X0];
    assign x1  = r_commit[dnn_pkg::IDX_X1];
    assign x2  = r_commit[dnn_pkg::IDX_X2];
    assign x3  = r_commit[dnn_pkg::IDX_X3];
    assign w04 = r_commit[dnn_pkg::IDX_W04];
    assign w05 = r_commit[dnn_pkg::IDX_W05];
    assign w06 = r_commit[dnn_pkg::IDX_W06];
    assign w07 = r_commit[dnn_pkg::IDX_W07];
    assign w14 = r_commit[dnn_pkg::IDX_W14];
    assign w15 = r_commit[dnn_pkg::IDX_W15];
    assign w16 = r_commit[dnn_pkg::IDX_W16];
    assign w17 = r_commit[dnn_pkg::IDX_W17];
    assign w24 = r_commit[dnn_pkg::IDX_W24];
    assign w25 = r_commit[dnn_pkg::IDX_W25];
    assign w26 = r_commit[dnn_pkg::IDX_W26];
    assign w27 = r_commit[dnn_pkg::IDX_W27];
    assign w34 = r_commit[dnn_pkg::IDX_W34];
    assign w35 = r_commit[dnn_pkg::IDX_W35];
    assign w36 = r_commit[dnn_pkg::IDX_W36];
    assign w37 = r_commit[dnn_pkg::IDX_W37];
    assign w48 = r_commit[dnn_pkg::IDX_W48];
    assign w49 = r_commit[dnn_pkg::IDX_W49];
    assign w58 = r_commit[dnn_pkg::IDX_W58];
    assign w59 = r_commit[dnn_pkg::IDX_W59];
    assign w68 = r_commit[dnn_pkg::IDX_W68];
    assign w69 = r_commit[dnn_pkg::IDX_W69];
    assign w78 = r_commit[dnn_pkg::IDX_W78];
    assign w79 = r_commit[dnn_pkg::IDX_W79];

endmodule

// File: doc/dnn_stream_loader.md
Name: dnn_stream_loader

Overview:
- Upstream feeder for the dnn inference core.
- Receives a serial stream of 5-bit signed words over a valid/ready handshake and de-serialises them into the 4 input activations and the 24 weights (16 layer-1, 8 layer-2).
- Checks frame framing; on a good frame, commits everything atomically to the parallel outputs and issues a one-cycle in_ready pulse to the core.
- Input-only frames reuse the last committed weights.

Parameters:
DW, 5, word width of activations and weights (signed); the only supported value is 5, matching the core.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
s_data  input  DW  signed stream word
s_valid  input  1  s_data valid
s_last  input  1  marks final word of a frame; qualified by s_valid
s_ready  output  1  loader accepts a word this cycle
x0..x3  output  4 x DW  committed input activations
w04..w07, w14..w17, w24..w27, w34..w37  output  16 x DW  committed layer-1 weights
w48, w49, w58, w59, w68, w69, w78, w79  output  8 x DW  committed layer-2 weights
in_ready  output  1  one-cycle pulse: all outputs hold a fresh frame
w_valid  output  1  a full weight set has been committed since reset
frame_err  output  1  one-cycle pulse: a malformed frame was dropped

Behaviour:
- Handshake: a word is accepted when s_valid && s_ready at a rising edge. s_ready is a combinational decode of state: 1 in LOAD, 0 in FIRE.
- Full frame: 28 words in this order: x0,x1,x2,x3, w04,w05,w06,w07, w14,...,w17, w24,...,w27, w34,...,w37, w48,w49,w58,w59,w68,w69,w78,w79. s_last is asserted on word 28 only.
- Input-only frame: 4 words x0..x3, with s_last on word 4. It is legal only when w_valid=1.
- Accepted words are written into staging registers, indexed by a 5-bit word counter (0..27). Outputs never change while a frame is loading.
- FSM states:
  - LOAD: accept words. On a good last word, commit and go to FIRE.
  - FIRE: lasts one cycle; in_ready=1, s_ready=0; then return to LOAD with counter=0.
- Commit happens at the edge that accepts a good last word:
  - Staged x0..x3 are copied to the x outputs.
  - For a full frame, all 24 staged weights are also copied, and w_valid is set to 1.
  - For an input-only frame, the weight outputs are unchanged.
- Output stability: all outputs are stable for the whole in_ready cycle and are held until the next commit. The core samples both layers' weights on the in_ready edge, so this stability is mandatory.
- Latency: in_ready is high in the cycle after the last word is accepted. Maximum throughput is one full frame per 29 cycles, or one input-only frame per 5 cycles.
- Error cases. The word is accepted, staging is discarded, the counter is cleared, the state stays LOAD, and frame_err is high for the next cycle. There is no commit, no in_ready, and outputs and w_valid are unchanged. A word is an error when it is:
  - s_last at counter index 3 while w_valid=0;
  - s_last at any index other than 3 or 27;
  - index 27 accepted without s_last.
- Simultaneous events: in_ready and frame_err are never high in the same cycle. s_valid during FIRE is ignored (s_ready=0); the word stays pending for the source.
- Reset: state=LOAD, counter=0, all x/w outputs=0, in_ready=0, w_valid=0, frame_err=0; staging is cleared.
- Reset mid-frame drops the partial frame. The next accepted word is treated as x0.
- Arithmetic: s_data is stored bit-exact as signed DW; no sign extension or saturation.

Decomposition:
- Shared package dnn_pkg holds:
  - DW;
  - NUM_X=4, NUM_W1=16, NUM_W2=8;
  - FRAME_X_LEN=4, FRAME_FULL_LEN=28;
  - the word-index constants for each weight;
  - the loader state enum {LOAD, FIRE}.
- No sub-module is warranted. Staging and commit registers are flat arrays inside dnn_stream_loader. A top-level wrapper (separate block) connects the loader directly to dnn.

Test Plan:
- Full frame, words 1..28 (values +1..+12, -16..-1 cycling), s_last on word 28, s_valid held high. Expect: s_ready low only in the FIRE cycle; in_ready pulses exactly 1 cycle after word 28; x0=1, w04=5, w79 = 28th value; w_valid=1 from that cycle.
- Input-only frame before any full frame (4 words, s_last on word 4, after reset). Expect: frame_err pulse; no in_ready; all outputs remain 0.
- Full frame, then input-only frame x={-16,15,-1,0}. Expect: in_ready 1 cycle after word 4; x outputs updated; all 24 weights identical to the first frame.
- s_last on word 10 of a full frame, then a valid full frame. Expect: frame_err pulse; outputs unchanged from the prior commit; the following frame commits correctly starting at x0.
- 28th word without s_last. Expect: frame_err; no commit. Then stall s_valid randomly across a good frame; the committed values must be unaffected by bubbles.
- rst asserted at word 15 of a full frame. Expect: outputs=0, w_valid=0 next cycle. A subsequent full frame loads correctly from x0.
